updown_counter: RTL and testbench
=================================

// Module: updown_counter
// PURPOSE
//   Parametrised successor of the 8-bit loadable counter: WIDTH-bit up/down counter with programmable
//   top value, runtime prescaler, wrap/saturate/one-shot modes and registered event flags.
//   Sits in the user area as the timebase/event counter; C feeds downstream logic and top-level IO.
// PARAMETERS
//   WIDTH    8    counter width in bits
//   MAX_VAL  255  top count value; counting range is 0..MAX_VAL (MAX_VAL <= 2**WIDTH-1)
//   PRE_W    4    prescaler divide-field width
// PORTS
//   CLK      in   1      single clock; all logic rising-edge
//   RESET_N  in   1      synchronous, active-low reset
//   vccd1    inout 1     power, only under `ifdef USE_POWER_PINS
//   vssd1    inout 1     ground, only under `ifdef USE_POWER_PINS
//   EN       in   1      count enable; gates prescaler and counter
//   UP       in   1      1 = count up, 0 = count down; sampled per count step
//   MODE     in   2      0 wrap, 1 saturate, 2 one-shot, 3 reserved (behaves as wrap)
//   DIV      in   PRE_W  counter steps once per DIV+1 enabled cycles (0 = every cycle)
//   LOAD     in   1      synchronous load of VALUE
//   VALUE    in   WIDTH  load value
//   C        out  WIDTH  current count
//   WRAP     out  1      1-cycle pulse: the step that produced C crossed a boundary (wrap mode)
//   AT_END   out  1      level: C == MAX_VAL when UP=1, C == 0 when UP=0 (registered with C)
//   DONE     out  1      one-shot mode: sticky, set when end reached; cleared by LOAD or reset
// BEHAVIOUR
//   - Reset (RESET_N=0 at CLK edge): C=0, WRAP=0, AT_END=0, DONE=0, prescaler count=0. Overrides all.
//   - Priority per edge: reset > LOAD > count step > hold.
//   - LOAD: C <= min(VALUE, MAX_VAL); prescaler cleared; DONE cleared; WRAP=0. New C visible next cycle.
//   - Prescaler: when EN=1, pcnt increments; when pcnt == DIV, step fires this edge and pcnt <= 0.
//     EN=0 freezes pcnt and C. DIV changed mid-count: if pcnt > new DIV, step fires next enabled edge.
//   - Step, UP=1: C<MAX_VAL -> C+1. At MAX_VAL: wrap -> 0 with WRAP=1; saturate -> hold;
//     one-shot -> hold, DONE=1.
//   - Step, UP=0: C>0 -> C-1. At 0: wrap -> MAX_VAL with WRAP=1; saturate -> hold; one-shot -> hold, DONE=1.
//   - One-shot with DONE=1: no further steps until LOAD or reset, regardless of EN/UP.
//   - WRAP is high exactly in the cycle C shows the wrapped value; low otherwise.
//   - AT_END is registered, recomputed from next-C and current UP; a UP toggle updates it next edge.
//   - Arithmetic modulo 2**WIDTH never used directly: boundary compare against MAX_VAL/0 first.
//   - Latency: EN/UP/LOAD sampled at edge N, C updated at edge N, visible after edge N.
//   - Reset asserted mid-prescale or mid-one-shot: everything returns to reset values, no residual flags.
// STRUCTURE
//   - Shared header counter_defs.vh: MODE_WRAP=2'd0, MODE_SAT=2'd1, MODE_ONESHOT=2'd2 localparams.
//   - Sub-module counter_prescaler (PRE_W): CLK, RESET_N, EN, CLR, DIV -> STEP strobe.
//   - Top holds count register, next-state mux, flag registers. Target 150-250 lines.
// TESTING (WIDTH=8, MAX_VAL=99, PRE_W=4, 20 ns clock)
//   1. Reset 2 cycles, EN=1 UP=1 MODE=0 DIV=0, 100 cycles -> C 0..99, then C=0 with WRAP=1 for 1 cycle.
//   2. LOAD VALUE=42 then UP=0 MODE=1 -> C counts 41..0, holds 0, AT_END=1, WRAP never asserts.
//   3. LOAD VALUE=200 -> C=99 (clamped); UP=1 MODE=2 one step -> DONE=1, C stays 99 for 20 cycles.
//   4. DIV=3, EN=1 from C=0 -> C increments every 4th cycle; EN=0 for 5 cycles -> C and phase frozen.
//   5. LOAD and step on same edge at C=10, VALUE=5 -> C=5, prescaler restarted, DONE=0.
//   6. RESET_N low for one edge mid-count (C=57, DIV=2, DONE=1) -> C=0, all flags 0 next cycle.

Source files
------------

// File: rtl/updown_counter_pkg.sv
// Shared definitions for the up/down counter: counting-mode encoding.
package updown_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

endpackage

// File: rtl/updown_counter_prescaler.sv
// Runtime-programmable prescaler: strobes STEP once every DIV+1 enabled cycles.
module updown_counter_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             EN,
    input  logic             CLR,
    input  logic [PRE_W-1:0] DIV,
    output logic             STEP
);

    logic [PRE_W-1:0] pcnt_q;
    logic [PRE_W-1:0] pcnt_d;

    // ">=" rather than "==" so a DIV lowered below the running count fires at once
    always_comb begin
        STEP   = EN && !CLR && (pcnt_q >= DIV);
        pcnt_d = pcnt_q;
        if (CLR) begin
            pcnt_d = '0;
        end else if (EN) begin
            pcnt_d = STEP ? '0 : pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/updown_counter.sv
// WIDTH-bit up/down counter with programmable top value, prescaler,
// wrap/saturate/one-shot modes and registered WRAP/AT_END/DONE flags.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 255,
    parameter int PRE_W   = 4
) (
`ifdef USE_POWER_PINS
    inout  wire              vccd1,
    inout  wire              vssd1,
`endif
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             EN,
    input  logic             UP,
    input  logic [1:0]       MODE,
    input  logic [PRE_W-1:0] DIV,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] VALUE,
    output logic [WIDTH-1:0] C,
    output logic             WRAP,
    output logic             AT_END,
    output logic             DONE
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic             step;
    logic [WIDTH-1:0] c_q, c_d;
    logic             wrap_q, wrap_d;
    logic             at_end_q, at_end_d;
    logic             done_q, done_d;
    mode_e            mode;

    assign mode = mode_e'(MODE);

    updown_counter_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .EN      (EN),
        .CLR     (LOAD),
        .DIV     (DIV),
        .STEP    (step)
    );

    // Boundaries are compared before any +1/-1 so the range stays 0..MAX_VAL
    always_comb begin
        c_d    = c_q;
        wrap_d = 1'b0;
        done_d = done_q;
        if (LOAD) begin
            c_d    = (VALUE > MAX_C) ? MAX_C : VALUE;
            done_d = 1'b0;
        end else if (step && !done_q) begin
            if (UP ? (c_q != MAX_C) : (c_q != '0)) begin
                c_d = UP ? c_q + 1'b1 : c_q - 1'b1;
            end else begin
                case (mode)
                    MODE_SAT:     c_d = c_q;
                    MODE_ONESHOT: done_d = 1'b1;
                    default: begin
                        c_d    = UP ? '0 : MAX_C;
                        wrap_d = 1'b1;
                    end
                endcase
            end
        end
        at_end_d = UP ? (c_d == MAX_C) : (c_d == '0);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            c_q      <= '0;
            wrap_q   <= 1'b0;
            at_end_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            c_q      <= c_d;
            wrap_q   <= wrap_d;
            at_end_q <= at_end_d;
            done_q   <= done_d;
        end
    end

    assign C      = c_q;
    assign WRAP   = wrap_q;
    assign AT_END = at_end_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed and randomized bench for updown_counter against an integer reference model.
module tb_updown_counter;

    localparam int WIDTH   = 8;
    localparam int MAX_VAL = 99;
    localparam int PRE_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             up;
    logic [1:0]       mode;
    logic [PRE_W-1:0] div;
    logic             load;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] c;
    logic             wrap;
    logic             at_end;
    logic             done;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_c = 0, m_p = 0;
    bit m_wrap = 0, m_end = 0, m_done = 0;

    updown_counter #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .PRE_W   (PRE_W)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .EN      (en),
        .UP      (up),
        .MODE    (mode),
        .DIV     (div),
        .LOAD    (load),
        .VALUE   (value),
        .C       (c),
        .WRAP    (wrap),
        .AT_END  (at_end),
        .DONE    (done)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit fire;
        if (!rst_n) begin
            m_c = 0; m_p = 0; m_wrap = 0; m_end = 0; m_done = 0;
            return;
        end
        m_wrap = 0;
        if (load) begin
            m_c    = (int'(value) > MAX_VAL) ? MAX_VAL : int'(value);
            m_p    = 0;
            m_done = 0;
        end else if (en) begin
            fire = (m_p >= int'(div));
            m_p  = fire ? 0 : m_p + 1;
            if (fire && !m_done) begin
                if (up && m_c < MAX_VAL)       m_c = m_c + 1;
                else if (!up && m_c > 0)       m_c = m_c - 1;
                else if (mode == 2'd1)         m_c = m_c;
                else if (mode == 2'd2)         m_done = 1;
                else begin
                    m_c    = up ? 0 : MAX_VAL;
                    m_wrap = 1;
                end
            end
        end
        m_end = up ? (m_c == MAX_VAL) : (m_c == 0);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("c",      int'(c),      m_c);
            chk("wrap",   int'(wrap),   int'(m_wrap));
            chk("at_end", int'(at_end), int'(m_end));
            chk("done",   int'(done),   int'(m_done));
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b1; mode = 2'd0;
        div = '0; load = 1'b0; value = '0;

        // reset
        tick(2);
        chk("reset_c", int'(c), 0);
        chk("reset_flags", int'({wrap, at_end, done}), 0);

        // count up through full range and wrap
        rst_n = 1'b1; en = 1'b1;
        tick(99);
        chk("t1_top", int'(c), 99);
        tick(1);
        chk("t1_wrap_c", int'(c), 0);
        chk("t1_wrap_flag", int'(wrap), 1);
        tick(1);
        chk("t1_wrap_pulse", int'(wrap), 0);

        // load 42, count down and saturate at 0
        load = 1'b1; value = 8'd42;
        tick(1);
        chk("t2_load", int'(c), 42);
        load = 1'b0; up = 1'b0; mode = 2'd1;
        tick(50);
        chk("t2_hold0", int'(c), 0);
        chk("t2_at_end", int'(at_end), 1);

        // clamped load, one-shot completion
        load = 1'b1; value = 8'd200;
        tick(1);
        chk("t3_clamp", int'(c), 99);
        load = 1'b0; up = 1'b1; mode = 2'd2;
        tick(1);
        chk("t3_done", int'(done), 1);
        tick(20);
        chk("t3_hold", int'(c), 99);
        chk("t3_done_sticky", int'(done), 1);

        // prescaler divide by 4, then freeze
        mode = 2'd0; div = 4'd3; load = 1'b1; value = 8'd0;
        tick(1);
        load = 1'b0;
        tick(12);
        chk("t4_div4", int'(c), 3);
        en = 1'b0;
        tick(5);
        chk("t4_frozen", int'(c), 3);
        en = 1'b1;
        tick(6);

        // load wins over a step on the same edge
        div = 4'd0; load = 1'b1; value = 8'd10;
        tick(1);
        value = 8'd5;
        tick(1);
        chk("t5_load_prio", int'(c), 5);
        load = 1'b0;
        tick(3);

        // reset mid-prescale and mid-one-shot
        load = 1'b1; value = 8'd57; div = 4'd2;
        tick(1);
        load = 1'b0;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        chk("t6_rst_c", int'(c), 0);
        rst_n = 1'b1; mode = 2'd2; div = 4'd0; load = 1'b1; value = 8'd99;
        tick(1);
        load = 1'b0;
        tick(3);
        chk("t6_done_before", int'(done), 1);
        rst_n = 1'b0;
        tick(1);
        chk("t6_rst_flags", int'({wrap, at_end, done}), 0);
        rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(63) != 0);
            load  = ($urandom_range(15) == 0);
            en    = ($urandom_range(3) != 0);
            up    = ($urandom_range(7) != 0) ? up : ~up;
            if ($urandom_range(31) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(7) == 0)  div  = PRE_W'($urandom_range(3));
            value = WIDTH'($urandom_range(255));
            tick(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
